tt_um_counter_checker: RTL and testbench
========================================

# tt_um_counter_checker

Receiving end of the 8-bit counter pin interface: samples a free-running counter value driven by an external source onto `ui_in`, synchronises and debounces it, and checks that successive accepted values increment by exactly one modulo 2^BW. It locks after a run of correct increments, counts sequence errors, and reports status and the error count on the TinyTapeout pins. It is the loopback and board-level checker for the counter top.

## Interface
Parameters:
- `BW`, 8: data width of the sampled counter value.
- `STABLE_CYC`, 2: consecutive equal synchronised samples required before a value is accepted (≥1).
- `LOCK_CNT`, 4: consecutive correct increments required to enter LOCKED (≥1).
- `TIMEOUT`, 1024: LOCKED watchdog limit in clock cycles (used only with the macro).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `ui_in`  in  8  external counter value (asynchronous to `clk`).
- `uio_in`  in  8  bit0 = display select (0: error count, 1: last accepted value); bit1 = clear error count (level); bits 7:2 unused.
- `uo_out`  out  8  error count or last accepted value, per select.
- `uio_out`  out  8  bit4 locked, bit5 acquiring, bit6 error pulse, bit7 timeout pulse; bits 3:0 = 0.
- `uio_oe`  out  8  constant 8'hF0.
- `ena`  in  1  ignored.

## Operation
- Input path: `ui_in` and `uio_in[1:0]` pass through a 2-flop synchroniser (s1→s2).
- Stability filter: `stab_cnt` resets to 0 when s2 differs from its previous value; otherwise increments, saturating at STABLE_CYC. A value is stable when `stab_cnt == STABLE_CYC`.
- Acceptance: sample event `smp` is a one-cycle pulse when the value is stable and either the state is IDLE or the value differs from `cur`. `cur` loads on every `smp`.
- FSM:
  - IDLE (reset state): first `smp` → ACQUIRE, `match_cnt` = 0.
  - ACQUIRE: on `smp`, if value == `cur`+1 (mod 2^BW), increment `match_cnt`; when it reaches LOCK_CNT → LOCKED. Otherwise `match_cnt` = 0.
  - LOCKED: on `smp`, value == `cur`+1 → stay. Otherwise → ACQUIRE, `match_cnt` = 0, error event.
- Wrap-around: 8'hFF → 8'h00 is a correct increment.
- Error event: `err_cnt` (BW bits) increments, saturating at 2^BW−1. `uio_out[6]` pulses high for one cycle.
- Clear: synchronised `uio_in[1]` high zeroes `err_cnt`. If a clear and an error event occur in the same cycle, the result is `err_cnt` = 1. FSM state is unaffected.
- Outputs: `uio_out[4]` = (state == LOCKED); `uio_out[5]` = (state == ACQUIRE); IDLE drives both 0.

## Timing
- Reset values: `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hF0, state IDLE, `cur` = 0, `err_cnt` = 0, all counters 0.
- Latency: `ui_in` changes and is held from edge N → `smp` asserts in the cycle after edge N+2+STABLE_CYC. State, `cur`, `err_cnt` and the pulses are registered and update on the following edge.
- Status and pulse outputs are registered; `uo_out` is a combinational mux of registered values.
- An input that toggles faster than STABLE_CYC+1 cycles is never accepted and produces no events.
- Reset mid-operation clears everything asynchronously. The first accepted value after reset never counts as an error.

## Configuration
- `COUNTER_CHECKER_TIMEOUT_EN` defined: a watchdog counts cycles since the last `smp` while LOCKED. When it reaches TIMEOUT: error event, `uio_out[7]` pulses for one cycle, state → ACQUIRE, `match_cnt` = 0. The watchdog reloads on every `smp` and on leaving LOCKED.
- Not defined: no watchdog logic, `uio_out[7]` is tied to 0, and LOCKED is held indefinitely without input activity.

## Test plan
- Reset, then drive 0x10, 0x11, 0x12, 0x13, 0x14, each held 8 cycles → ACQUIRE after 0x10; locked (`uio_out[4]` = 1) after the 0x14 acceptance; `err_cnt` = 0.
- While locked at 0x14, drive 0x20 → one `uio_out[6]` pulse, state ACQUIRE, `uo_out` = 0x01 with select = 0. With select = 1, `uo_out` = 0x20.
- Lock on 0xFC..0xFF, then drive 0x00 → no error, remains LOCKED.
- Toggle `ui_in` between 0x33 and 0x44 every cycle for 50 cycles while locked → no `smp`, no error, `cur` unchanged.
- Force 300 errors with alternating bad values → `err_cnt` saturates at 0xFF. Assert `uio_in[1]` for 4 cycles → 0x00. Clear coincident with an error → 0x01.
- Macro defined, TIMEOUT = 1024: lock, then hold `ui_in` constant → `uio_out[7]` and `uio_out[6]` pulse together 1024 cycles after the last `smp`, state ACQUIRE, `err_cnt` +1. Macro undefined: still LOCKED after 5000 cycles.

Source files
------------

// File: rtl/tt_um_counter_checker.sv
// tt_um_counter_checker: receiving end of the 8-bit counter pin interface.
// Synchronises and debounces the external counter on ui_in and checks that
// successive accepted values increment by one. It locks after a run of good
// increments and counts sequence errors.
// Optional LOCKED watchdog: define COUNTER_CHECKER_TIMEOUT_EN.
module tt_um_counter_checker #(
  parameter int BW         = 8,
  parameter int STABLE_CYC = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int SW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [BW-1:0] ERR_MAX = {BW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // synchroniser: {clear, select, value}
  logic [BW+1:0] s1_q, s2_q;
  logic [BW-1:0] s2_val_s;
  logic          sel_s, clr_s;

  // stability filter
  logic [BW-1:0] prev_q, prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          stable_s, smp_s, inc_ok_s;

  // checker core
  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [BW-1:0] cur_q, cur_d;
  logic [BW-1:0] err_q, err_d;
  logic          err_ev_s, to_ev_s;
  logic          lock_q, lock_d, acq_q, acq_d, perr_q, perr_d, pto_q, pto_d;

  logic          unused_s;

  assign s2_val_s = s2_q[BW-1:0];
  assign sel_s    = s2_q[BW];
  assign clr_s    = s2_q[BW+1];

  // Two-flop synchroniser for the counter value and the two control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= {(BW+2){1'b0}};
      s2_q <= {(BW+2){1'b0}};
    end else begin
      s1_q <= {uio_in[1:0], ui_in[BW-1:0]};
      s2_q <= s1_q;
    end
  end

  // Count how long the synchronised value has been unchanged, saturating.
  always_comb begin
    prev_d = s2_val_s;
    if (s2_val_s != prev_q) begin
      stab_d = {SW{1'b0}};
    end else if (stab_q != SW'(STABLE_CYC)) begin
      stab_d = stab_q + SW'(1);
    end else begin
      stab_d = stab_q;
    end
  end

  // The value judged stable is prev_q, the one stab_q has been counting.
  assign stable_s = (stab_q == SW'(STABLE_CYC));
  assign smp_s    = stable_s && ((state_q == ST_IDLE) || (prev_q != cur_q));
  assign inc_ok_s = (prev_q == (cur_q + BW'(1)));

`ifdef COUNTER_CHECKER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_fire_s;

  // Watchdog: cycles since the last accepted sample while LOCKED.
  always_comb begin
    wd_fire_s = 1'b0;
    if ((state_q == ST_LOCK) && !smp_s) begin
      if (wd_q == WW'(TIMEOUT - 1)) begin
        wd_fire_s = 1'b1;
        wd_d      = {WW{1'b0}};
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end else begin
      wd_d = {WW{1'b0}};
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= {WW{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end

  assign unused_s = &{1'b0, ena, uio_in[7:2]};
`else
  logic        wd_fire_s;
  logic [31:0] unused_timeout_s;

  assign wd_fire_s        = 1'b0;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign unused_s         = &{1'b0, ena, uio_in[7:2], unused_timeout_s};
`endif

  // Sequence FSM, error counter and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cur_d    = cur_q;
    err_ev_s = 1'b0;
    to_ev_s  = 1'b0;
    if (smp_s) begin
      cur_d = prev_q;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          match_d = {MW{1'b0}};
        end
        ST_ACQ: begin
          if (inc_ok_s) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = ST_LOCK;
              match_d = {MW{1'b0}};
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = {MW{1'b0}};
          end
        end
        ST_LOCK: begin
          if (inc_ok_s) begin
            state_d = ST_LOCK;
          end else begin
            state_d  = ST_ACQ;
            match_d  = {MW{1'b0}};
            err_ev_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          match_d = {MW{1'b0}};
        end
      endcase
    end else if (wd_fire_s) begin
      state_d  = ST_ACQ;
      match_d  = {MW{1'b0}};
      err_ev_s = 1'b1;
      to_ev_s  = 1'b1;
    end else begin
      state_d = state_q;
    end

    // A clear wins over accumulated history but not over a same-cycle error.
    if (clr_s) begin
      err_d = err_ev_s ? BW'(1) : {BW{1'b0}};
    end else if (err_ev_s && (err_q != ERR_MAX)) begin
      err_d = err_q + BW'(1);
    end else begin
      err_d = err_q;
    end

    lock_d = (state_d == ST_LOCK);
    acq_d  = (state_d == ST_ACQ);
    perr_d = err_ev_s;
    pto_d  = to_ev_s;
  end

  // Filter, FSM, counters and status/pulse output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= {BW{1'b0}};
      stab_q  <= {SW{1'b0}};
      state_q <= ST_IDLE;
      match_q <= {MW{1'b0}};
      cur_q   <= {BW{1'b0}};
      err_q   <= {BW{1'b0}};
      lock_q  <= 1'b0;
      acq_q   <= 1'b0;
      perr_q  <= 1'b0;
      pto_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      match_q <= match_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      acq_q   <= acq_d;
      perr_q  <= perr_d;
      pto_q   <= pto_d;
    end
  end

  assign uo_out  = sel_s ? 8'(cur_q) : 8'(err_q);
  assign uio_out = {pto_q, perr_q, acq_q, lock_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_counter_checker.sv
// Randomised and directed bench for tt_um_counter_checker with a behavioural
// reference model compared against the outputs on every falling clock edge.
module tb_tt_um_counter_checker;

  localparam int S    = 2;
  localparam int LCK  = 4;
  localparam int TOUT = 1024;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_counter_checker #(
    .BW(8), .STABLE_CYC(S), .LOCK_CNT(LCK), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .ena(ena)
  );

  int vectors = 0;
  int miscompares = 0;
  bit run_chk = 1'b0;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ACQ, M_LOCK} mstate_t;
  mstate_t      m_st;
  byte unsigned uh[$];   // ui_in sampled per edge, u[j] at index j+2
  bit           ch[$];   // clear bit, same indexing
  bit           sh[$];   // select bit, same indexing
  int           k;       // edges since reset
  int           m_mc, m_wd;
  byte unsigned m_cur, m_err;
  bit           m_perr, m_pto, m_sel;
  logic [7:0]   exp_uo, exp_uio;

  function automatic void m_outputs();
    exp_uo  = m_sel ? m_cur : m_err;
    exp_uio = {m_pto, m_perr, (m_st == M_ACQ), (m_st == M_LOCK), 4'b0000};
  endfunction

  function automatic void m_reset();
    // synchroniser and filter registers clear to zero: pretend u[-2..0] = 0
    uh = '{8'h00, 8'h00, 8'h00};
    ch = '{1'b0, 1'b0, 1'b0};
    sh = '{1'b0, 1'b0, 1'b0};
    k = 0; m_st = M_IDLE; m_mc = 0; m_wd = 0;
    m_cur = 8'h00; m_err = 8'h00; m_perr = 1'b0; m_pto = 1'b0; m_sel = 1'b0;
    m_outputs();
  endfunction

  function automatic void m_step();
    bit stable, smp, clr, ev, to;
    byte unsigned v, nx;
    // a value is accepted once the twice-delayed stream has shown it S+1 times
    stable = (k >= S);
    if (stable) begin
      for (int j = k - S; j < k; j++) if (uh[j] != uh[k]) stable = 1'b0;
    end
    v     = uh[k];
    clr   = ch[k+1];
    m_sel = sh[k+2];
    nx    = m_cur + 8'd1;
    smp   = stable && ((m_st == M_IDLE) || (v != m_cur));
    ev = 1'b0; to = 1'b0;
    if (smp) begin
      if (m_st == M_IDLE) begin
        m_st = M_ACQ; m_mc = 0;
      end else if (m_st == M_ACQ) begin
        if (v == nx) begin
          m_mc++;
          if (m_mc == LCK) m_st = M_LOCK;
        end else m_mc = 0;
      end else if (v != nx) begin
        m_st = M_ACQ; m_mc = 0; ev = 1'b1;
      end
      m_cur = v;
      m_wd  = 0;
    end
`ifdef COUNTER_CHECKER_TIMEOUT_EN
    else if (m_st == M_LOCK) begin
      m_wd++;
      if (m_wd == TOUT) begin
        to = 1'b1; ev = 1'b1; m_st = M_ACQ; m_mc = 0; m_wd = 0;
      end
    end
`endif
    if (m_st != M_LOCK) m_wd = 0;
    if (clr) m_err = ev ? 8'd1 : 8'd0;
    else if (ev && (m_err != 8'hFF)) m_err = m_err + 8'd1;
    m_perr = ev;
    m_pto  = to;
    uh.push_back(ui_in);
    ch.push_back(uio_in[1]);
    sh.push_back(uio_in[0]);
    k++;
    m_outputs();
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (run_chk) begin
      vectors++;
      if ((uo_out !== exp_uo) || (uio_out !== exp_uio) || (uio_oe !== 8'hF0)) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t got uo_out=%h uio_out=%h uio_oe=%h, expected %h %h f0",
                 $time, uo_out, uio_out, uio_oe, exp_uo, exp_uio);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    ui_in = v;
    repeat (n) @(negedge clk);
  endtask

  byte unsigned tb_cur, bad;
  int pulses;
  int r;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);

    // lock on 0x10..0x14
    for (int i = 0; i < 5; i++) hold(8'h10 + 8'(i), 8);
    #1;
    check("locked_after_14", uio_out, 8'h10);
    check("err_cnt_zero", uo_out, 8'h00);

    // break the sequence while locked
    ui_in = 8'h20;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uio_out[6]) pulses++;
    end
    #1;
    check("single_err_pulse", 8'(pulses), 8'h01);
    check("acquire_after_err", uio_out, 8'h20);
    check("err_cnt_one", uo_out, 8'h01);
    uio_in[0] = 1'b1;
    hold(8'h20, 4);
    #1;
    check("display_last_value", uo_out, 8'h20);
    uio_in[0] = 1'b0;
    hold(8'h20, 4);

    // wrap-around FF -> 00 while locked
    for (int i = 0; i < 5; i++) hold(8'hFB + 8'(i), 8);
    hold(8'h00, 8);
    #1;
    check("wrap_still_locked", uio_out, 8'h10);
    check("wrap_no_error", uo_out, 8'h01);

    // fast toggling is filtered out
    for (int i = 0; i < 50; i++) begin
      ui_in = (i % 2 == 1) ? 8'h44 : 8'h33;
      @(negedge clk);
    end
    hold(8'h00, 8);
    #1;
    check("toggle_still_locked", uio_out, 8'h10);
    check("toggle_no_error", uo_out, 8'h01);
    uio_in[0] = 1'b1;
    hold(8'h00, 4);
    #1;
    check("toggle_cur_unchanged", uo_out, 8'h00);
    uio_in[0] = 1'b0;
    hold(8'h00, 4);

    // 300 errors saturate the counter
    tb_cur = 8'h00;
    for (int e = 0; e < 300; e++) begin
      tb_cur = (e % 2 == 1) ? tb_cur + 8'd2 : tb_cur + 8'h80;
      hold(tb_cur, 6);
      for (int i = 0; i < LCK; i++) begin
        tb_cur = tb_cur + 8'd1;
        hold(tb_cur, 6);
      end
    end
    #1;
    check("err_saturated", uo_out, 8'hFF);
    check("locked_after_burst", uio_out, 8'h10);

    // level clear
    uio_in[1] = 1'b1;
    hold(tb_cur, 4);
    uio_in[1] = 1'b0;
    hold(tb_cur, 4);
    #1;
    check("err_cleared", uo_out, 8'h00);

    // clear coincident with an error event
    bad = tb_cur + 8'h55;
    ui_in = bad;
    repeat (3) @(negedge clk);
    uio_in[1] = 1'b1;
    @(negedge clk);
    uio_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("clear_with_error", uo_out, 8'h01);
    check("acq_after_clear_err", uio_out, 8'h20);
    tb_cur = bad;

    // relock, then hold the input constant
    for (int i = 0; i < LCK; i++) begin
      tb_cur = tb_cur + 8'd1;
      hold(tb_cur, 6);
    end
`ifdef COUNTER_CHECKER_TIMEOUT_EN
    pulses = 0;
    for (int i = 0; i < TOUT + 50; i++) begin
      @(negedge clk);
      if (uio_out[7] && uio_out[6]) pulses++;
    end
    #1;
    check("timeout_pulse", 8'(pulses), 8'h01);
    check("acq_after_timeout", uio_out, 8'h20);
    check("err_after_timeout", uo_out, 8'h02);
`else
    hold(tb_cur, 5000);
    #1;
    check("locked_without_watchdog", uio_out, 8'h10);
    check("no_err_without_watchdog", uo_out, 8'h01);
`endif
    @(negedge clk);

    // randomised phase with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_uo_out", uo_out, 8'h00);
        check("midrun_reset_uio_out", uio_out, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tb_cur = 8'h00;
      end
      r = int'($urandom_range(0, 9));
      if (r < 7) tb_cur = tb_cur + 8'd1;
      else tb_cur = 8'($urandom);
      uio_in[0] = 1'($urandom_range(0, 1));
      uio_in[1] = ($urandom_range(0, 19) == 0);
      hold(tb_cur, int'($urandom_range(1, 7)));
    end
    uio_in = 8'h00;
    repeat (10) @(negedge clk);
    run_chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
